// File: rtl/soc_it_axi_pkg.sv
// Shared types and constants for the SoC-IT to AXI4 master control path.
// The descriptor struct mirrors the xfer_params bit layout, LSB first: addr, len, rnw, start.
package soc_it_axi_pkg;

  localparam int ADDR_W = 64;
  localparam int LEN_W  = 13;

  localparam int DESC_ADDR_LSB  = 0;
  localparam int DESC_LEN_LSB   = ADDR_W;
  localparam int DESC_RNW_BIT   = ADDR_W + LEN_W;
  localparam int DESC_START_BIT = ADDR_W + LEN_W + 1;
  localparam int DESC_W         = ADDR_W + LEN_W + 2;

  typedef struct packed {
    logic              start;
    logic              rnw;
    logic [LEN_W-1:0]  len;
    logic [ADDR_W-1:0] addr;
  } desc_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WDATA,
    ST_WRESP,
    ST_RDATA
  } state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam int         BOUNDARY_4K    = 4096;
  localparam int         MAX_BEATS      = 256;

  function automatic int beat_size(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/soc_it_burst_splitter.sv
// Sizes the next AXI INCR burst so it stays inside one 4 KB page and within 256 beats,
// and returns the address and remaining beat count for the burst after it.
module soc_it_burst_splitter
  import soc_it_axi_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int BEATS_W = 13,
  parameter int BB_LOG2 = 4
) (
  input  logic [ADDR_W-1:0]  addr_i,
  input  logic [BEATS_W-1:0] beats_i,
  output logic [7:0]         len_o,
  output logic [ADDR_W-1:0]  next_addr_o,
  output logic [BEATS_W-1:0] next_beats_o
);

  localparam int W = (BEATS_W > 13) ? BEATS_W : 13;

  logic [W-1:0] room;
  logic [W-1:0] n;

  always_comb begin
    // NOTE: every combinational output gets a value on every path first, so no latch is inferred.
    room = W'((BOUNDARY_4K - int'(addr_i[11:0])) >> BB_LOG2);
    n    = W'(beats_i);
    if (n > W'(MAX_BEATS)) n = W'(MAX_BEATS);
    if (n > room)          n = room;
  end

  assign len_o        = 8'(n - W'(1));
  assign next_addr_o  = addr_i + (ADDR_W'(n) << BB_LOG2);
  assign next_beats_o = beats_i - BEATS_W'(n);

endmodule

// File: rtl/soc_it_axi_master.sv
// AXI4 master control path: takes one SoC-IT descriptor, issues page-safe INCR bursts one at a
// time, and steers the W/R beat handshakes between the SoC-IT stream and AXI.
module soc_it_axi_master
  import soc_it_axi_pkg::*;
#(
  parameter int C_DATA_WIDTH        = 128,
  parameter int C_SLV_ADDRESS_WIDTH = 64,
  parameter int C_SLV_BURST_LENGTH  = 13,
  parameter int XFER_PARAMS_WIDTH   = C_SLV_ADDRESS_WIDTH + C_SLV_BURST_LENGTH + 2
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [XFER_PARAMS_WIDTH-1:0]   xfer_params_i,
  input  logic                           xfer_params_req_i,
  output logic                           xfer_params_ack_o,
  input  logic                           soc_it_wvalid_i,
  output logic                           soc_it_wready_o,
  input  logic                           soc_it_wlast_i,
  output logic                           soc_it_rvalid_o,
  input  logic                           soc_it_rready_i,
  output logic                           soc_it_rlast_o,
  output logic [C_SLV_ADDRESS_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]                     m_axi_awlen,
  output logic [2:0]                     m_axi_awsize,
  output logic [1:0]                     m_axi_awburst,
  output logic                           m_axi_awvalid,
  input  logic                           m_axi_awready,
  output logic [C_SLV_ADDRESS_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                     m_axi_arlen,
  output logic [2:0]                     m_axi_arsize,
  output logic [1:0]                     m_axi_arburst,
  output logic                           m_axi_arvalid,
  input  logic                           m_axi_arready,
  output logic                           m_axi_wvalid,
  input  logic                           m_axi_wready,
  output logic                           m_axi_wlast,
  input  logic                           m_axi_bvalid,
  output logic                           m_axi_bready,
  input  logic [1:0]                     m_axi_bresp,
  input  logic                           m_axi_rvalid,
  output logic                           m_axi_rready,
  input  logic                           m_axi_rlast,
  input  logic [1:0]                     m_axi_rresp,
  output logic                           busy_o,
  output logic                           err_o
);

  localparam int A       = C_SLV_ADDRESS_WIDTH;
  localparam int L       = C_SLV_BURST_LENGTH;
  localparam int BB      = beat_size(C_DATA_WIDTH);
  localparam int BB_LOG2 = $clog2(BB);

  desc_t          desc_in;
  logic           unused_start;
  logic [A-1:0]   desc_addr;
  logic [L-1:0]   desc_beats;

  state_e         state_q, state_d;
  logic [A-1:0]   addr_q, addr_d, next_addr_q, next_addr_d;
  logic [L-1:0]   beats_left_q, beats_left_d;
  logic [7:0]     len_q, len_d, beat_cnt_q, beat_cnt_d;
  logic           rnw_q, rnw_d, err_flag_q, err_flag_d;
  logic           ack_q, ack_d, busy_q, busy_d, err_q, err_d;
  logic           awvalid_q, awvalid_d, arvalid_q, arvalid_d;

  logic [A-1:0]   split_addr, split_next_addr;
  logic [L-1:0]   split_beats, split_next_beats;
  logic [7:0]     split_len;
  logic           w_phase, r_phase, w_hs, r_hs, burst_last, desc_last;
  logic           launch, burst_done;

  assign desc_in      = desc_t'(xfer_params_i);
  assign unused_start = desc_in.start;
  assign desc_addr    = desc_in.addr & ~A'(BB - 1);
  assign desc_beats   = desc_in.len >> BB_LOG2;

  // While idle the splitter sizes the first burst straight from the incoming descriptor.
  assign split_addr  = (state_q == ST_IDLE) ? desc_addr  : next_addr_q;
  assign split_beats = (state_q == ST_IDLE) ? desc_beats : beats_left_q;

  soc_it_burst_splitter #(
    .ADDR_W  (A),
    .BEATS_W (L),
    .BB_LOG2 (BB_LOG2)
  ) u_splitter (
    .addr_i       (split_addr),
    .beats_i      (split_beats),
    .len_o        (split_len),
    .next_addr_o  (split_next_addr),
    .next_beats_o (split_next_beats)
  );

  assign w_phase    = (state_q == ST_WDATA);
  assign r_phase    = (state_q == ST_RDATA);
  assign burst_last = (beat_cnt_q == len_q);
  assign desc_last  = burst_last && (beats_left_q == '0);

  assign m_axi_wvalid    = w_phase & soc_it_wvalid_i;
  assign soc_it_wready_o = w_phase & m_axi_wready;
  assign m_axi_wlast     = w_phase & burst_last;
  assign m_axi_bready    = (state_q == ST_WRESP);
  assign m_axi_rready    = r_phase & soc_it_rready_i;
  assign soc_it_rvalid_o = r_phase & m_axi_rvalid;
  assign soc_it_rlast_o  = r_phase & m_axi_rlast & (beats_left_q == '0);
  assign w_hs            = m_axi_wvalid & m_axi_wready;
  assign r_hs            = soc_it_rvalid_o & m_axi_rready;

  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = len_q;
  assign m_axi_awsize  = 3'(BB_LOG2);
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = 3'(BB_LOG2);
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arvalid = arvalid_q;

  assign xfer_params_ack_o = ack_q;
  assign busy_o            = busy_q;
  assign err_o             = err_q;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    next_addr_d  = next_addr_q;
    beats_left_d = beats_left_q;
    len_d        = len_q;
    beat_cnt_d   = beat_cnt_q;
    rnw_d        = rnw_q;
    err_flag_d   = err_flag_q;
    busy_d       = busy_q;
    awvalid_d    = awvalid_q;
    arvalid_d    = arvalid_q;
    ack_d        = 1'b0;
    err_d        = 1'b0;
    launch       = 1'b0;
    burst_done   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // ack_q guards against re-accepting the same request while it is still held high.
        if (xfer_params_req_i && !ack_q) begin
          ack_d      = 1'b1;
          rnw_d      = desc_in.rnw;
          err_flag_d = |(desc_in.len & L'(BB - 1));
          if (desc_beats == '0) err_d = 1'b1;
          else begin
            busy_d = 1'b1;
            launch = 1'b1;
          end
        end
      end
      ST_ADDR: begin
        if (awvalid_q && m_axi_awready) begin
          awvalid_d = 1'b0;
          state_d   = ST_WDATA;
        end else if (arvalid_q && m_axi_arready) begin
          arvalid_d = 1'b0;
          state_d   = ST_RDATA;
        end
      end
      ST_WDATA: begin
        if (w_hs) begin
          if (soc_it_wlast_i != desc_last) err_flag_d = 1'b1;
          if (burst_last) begin
            beat_cnt_d = '0;
            state_d    = ST_WRESP;
          end else beat_cnt_d = beat_cnt_q + 8'd1;
        end
      end
      ST_WRESP: begin
        if (m_axi_bvalid) begin
          if (m_axi_bresp != AXI_RESP_OKAY) err_flag_d = 1'b1;
          burst_done = 1'b1;
        end
      end
      ST_RDATA: begin
        if (r_hs) begin
          if (m_axi_rresp != AXI_RESP_OKAY || m_axi_rlast != burst_last) err_flag_d = 1'b1;
          if (burst_last) begin
            beat_cnt_d = '0;
            burst_done = 1'b1;
          end else beat_cnt_d = beat_cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (burst_done) begin
      if (beats_left_q != '0) launch = 1'b1;
      else begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        err_d   = err_flag_d;
      end
    end

    if (launch) begin
      state_d      = ST_ADDR;
      addr_d       = split_addr;
      len_d        = split_len;
      next_addr_d  = split_next_addr;
      beats_left_d = split_next_beats;
      awvalid_d    = !rnw_d;
      arvalid_d    = rnw_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: flops take non-blocking assignments so every register samples pre-edge values.
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      next_addr_q  <= '0;
      beats_left_q <= '0;
      len_q        <= '0;
      beat_cnt_q   <= '0;
      rnw_q        <= 1'b0;
      err_flag_q   <= 1'b0;
      ack_q        <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      awvalid_q    <= 1'b0;
      arvalid_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      next_addr_q  <= next_addr_d;
      beats_left_q <= beats_left_d;
      len_q        <= len_d;
      beat_cnt_q   <= beat_cnt_d;
      rnw_q        <= rnw_d;
      err_flag_q   <= err_flag_d;
      ack_q        <= ack_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      awvalid_q    <= awvalid_d;
      arvalid_q    <= arvalid_d;
    end
  end

endmodule

// File: tb/tb_soc_it_axi_master.sv
// Directed bench for soc_it_axi_master: the bench plays both the SoC-IT requester and the AXI
// slave, with hand-computed expected burst addresses, lengths and last/err timing.
module tb_soc_it_axi_master;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic [78:0] xfer_params_i = '0;
  logic        xfer_params_req_i = 1'b0;
  logic        xfer_params_ack_o;
  logic        soc_it_wvalid_i = 1'b0, soc_it_wlast_i = 1'b0, soc_it_rready_i = 1'b0;
  logic        soc_it_wready_o, soc_it_rvalid_o, soc_it_rlast_o;
  logic [63:0] m_axi_awaddr, m_axi_araddr;
  logic [7:0]  m_axi_awlen, m_axi_arlen;
  logic [2:0]  m_axi_awsize, m_axi_arsize;
  logic [1:0]  m_axi_awburst, m_axi_arburst;
  logic        m_axi_awvalid, m_axi_arvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready, m_axi_rready;
  logic        m_axi_awready = 1'b0, m_axi_arready = 1'b0, m_axi_wready = 1'b0;
  logic        m_axi_bvalid = 1'b0, m_axi_rvalid = 1'b0, m_axi_rlast = 1'b0;
  logic [1:0]  m_axi_bresp = 2'b00, m_axi_rresp = 2'b00;
  logic        busy_o, err_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  soc_it_axi_master dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .xfer_params_i     (xfer_params_i),
    .xfer_params_req_i (xfer_params_req_i),
    .xfer_params_ack_o (xfer_params_ack_o),
    .soc_it_wvalid_i   (soc_it_wvalid_i),
    .soc_it_wready_o   (soc_it_wready_o),
    .soc_it_wlast_i    (soc_it_wlast_i),
    .soc_it_rvalid_o   (soc_it_rvalid_o),
    .soc_it_rready_i   (soc_it_rready_i),
    .soc_it_rlast_o    (soc_it_rlast_o),
    .m_axi_awaddr      (m_axi_awaddr),
    .m_axi_awlen       (m_axi_awlen),
    .m_axi_awsize      (m_axi_awsize),
    .m_axi_awburst     (m_axi_awburst),
    .m_axi_awvalid     (m_axi_awvalid),
    .m_axi_awready     (m_axi_awready),
    .m_axi_araddr      (m_axi_araddr),
    .m_axi_arlen       (m_axi_arlen),
    .m_axi_arsize      (m_axi_arsize),
    .m_axi_arburst     (m_axi_arburst),
    .m_axi_arvalid     (m_axi_arvalid),
    .m_axi_arready     (m_axi_arready),
    .m_axi_wvalid      (m_axi_wvalid),
    .m_axi_wready      (m_axi_wready),
    .m_axi_wlast       (m_axi_wlast),
    .m_axi_bvalid      (m_axi_bvalid),
    .m_axi_bready      (m_axi_bready),
    .m_axi_bresp       (m_axi_bresp),
    .m_axi_rvalid      (m_axi_rvalid),
    .m_axi_rready      (m_axi_rready),
    .m_axi_rlast       (m_axi_rlast),
    .m_axi_rresp       (m_axi_rresp),
    .busy_o            (busy_o),
    .err_o             (err_o)
  );

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_desc(input logic [63:0] addr, input logic [12:0] len, input logic rnw,
                           input logic exp_busy);
    xfer_params_i     = {1'b1, rnw, len, addr};
    xfer_params_req_i = 1'b1;
    #1;
    check_bit("ack_before_edge", xfer_params_ack_o, 1'b0);
    tick();
    check_bit("ack_pulse", xfer_params_ack_o, 1'b1);
    check_bit("busy_after_ack", busy_o, exp_busy);
    xfer_params_req_i = 1'b0;
  endtask

  task automatic addr_hs(input logic rnw, input logic [63:0] exp_addr, input logic [7:0] exp_len,
                         input int stall);
    for (int i = 0; i < stall; i++) begin
      soc_it_wvalid_i = 1'b1;
      m_axi_wready    = 1'b1;
      m_axi_rvalid    = 1'b1;
      soc_it_rready_i = 1'b1;
      #1;
      check_bit("addr_valid_held", rnw ? m_axi_arvalid : m_axi_awvalid, 1'b1);
      check_val("addr_stable", rnw ? m_axi_araddr : m_axi_awaddr, exp_addr);
      check_bit("no_w_in_addr", m_axi_wvalid | soc_it_wready_o, 1'b0);
      check_bit("no_r_in_addr", soc_it_rvalid_o | m_axi_rready, 1'b0);
      tick();
    end
    soc_it_wvalid_i = 1'b0;
    m_axi_wready    = 1'b0;
    m_axi_rvalid    = 1'b0;
    soc_it_rready_i = 1'b0;
    if (rnw) m_axi_arready = 1'b1;
    else     m_axi_awready = 1'b1;
    #1;
    check_bit("awvalid", m_axi_awvalid, !rnw);
    check_bit("arvalid", m_axi_arvalid, rnw);
    if (rnw) begin
      check_val("araddr", m_axi_araddr, exp_addr);
      check_val("arlen", 64'(m_axi_arlen), 64'(exp_len));
      check_val("arsize", 64'(m_axi_arsize), 64'd4);
      check_val("arburst", 64'(m_axi_arburst), 64'd1);
    end else begin
      check_val("awaddr", m_axi_awaddr, exp_addr);
      check_val("awlen", 64'(m_axi_awlen), 64'(exp_len));
      check_val("awsize", 64'(m_axi_awsize), 64'd4);
      check_val("awburst", 64'(m_axi_awburst), 64'd1);
    end
    tick();
    m_axi_awready = 1'b0;
    m_axi_arready = 1'b0;
    check_bit("valid_drop_after_hs", m_axi_awvalid | m_axi_arvalid, 1'b0);
    check_bit("ack_one_cycle", xfer_params_ack_o, 1'b0);
  endtask

  task automatic w_burst(input int n, input logic final_burst, input logic rnd);
    int   beat;
    int   guard;
    logic v;
    logic r;
    beat  = 0;
    guard = 0;
    while (beat < n && guard < 2000) begin
      v = rnd ? 1'($urandom_range(1)) : 1'b1;
      r = rnd ? 1'($urandom_range(1)) : 1'b1;
      soc_it_wvalid_i = v;
      m_axi_wready    = r;
      soc_it_wlast_i  = final_burst && (beat == n - 1);
      #1;
      check_bit("wvalid_steer", m_axi_wvalid, v);
      check_bit("wready_steer", soc_it_wready_o, r);
      if (v && r) begin
        check_bit("m_wlast", m_axi_wlast, beat == n - 1);
        beat++;
      end
      tick();
      guard++;
    end
    check_bit("w_beat_budget", beat == n, 1'b1);
    soc_it_wvalid_i = 1'b0;
    m_axi_wready    = 1'b0;
    soc_it_wlast_i  = 1'b0;
  endtask

  task automatic b_resp(input logic [1:0] resp);
    soc_it_wvalid_i = 1'b1;
    m_axi_wready    = 1'b1;
    m_axi_bvalid    = 1'b1;
    m_axi_bresp     = resp;
    #1;
    check_bit("bready", m_axi_bready, 1'b1);
    check_bit("no_w_in_resp", m_axi_wvalid | soc_it_wready_o, 1'b0);
    check_bit("no_aw_before_b", m_axi_awvalid, 1'b0);
    tick();
    soc_it_wvalid_i = 1'b0;
    m_axi_wready    = 1'b0;
    m_axi_bvalid    = 1'b0;
    m_axi_bresp     = 2'b00;
  endtask

  task automatic r_burst(input int n, input logic final_burst);
    for (int beat = 0; beat < n; beat++) begin
      m_axi_rvalid    = 1'b1;
      soc_it_rready_i = 1'b1;
      m_axi_rlast     = (beat == n - 1);
      #1;
      check_bit("rvalid_steer", soc_it_rvalid_o, 1'b1);
      check_bit("rready_steer", m_axi_rready, 1'b1);
      check_bit("soc_rlast", soc_it_rlast_o, final_burst && (beat == n - 1));
      tick();
    end
    m_axi_rvalid    = 1'b0;
    soc_it_rready_i = 1'b0;
    m_axi_rlast     = 1'b0;
  endtask

  task automatic finish_check(input logic exp_err);
    check_bit("busy_done", busy_o, 1'b0);
    check_bit("err_at_done", err_o, exp_err);
    tick();
    check_bit("err_single_cycle", err_o, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    rst_ni = 1'b0;
    tick();
    tick();
    check_bit("rst_awvalid", m_axi_awvalid, 1'b0);
    check_bit("rst_arvalid", m_axi_arvalid, 1'b0);
    check_bit("rst_ack", xfer_params_ack_o, 1'b0);
    check_bit("rst_busy", busy_o, 1'b0);
    check_bit("rst_err", err_o, 1'b0);
    check_bit("rst_bready", m_axi_bready, 1'b0);
    rst_ni = 1'b1;
    tick();

    // 1: single 4-beat write
    send_desc(64'h1000, 13'd64, 1'b0, 1'b1);
    addr_hs(1'b0, 64'h1000, 8'd3, 0);
    w_burst(4, 1'b1, 1'b0);
    b_resp(2'b00);
    finish_check(1'b0);

    // 2: write crossing the 4 KB page splits into two 4-beat bursts
    send_desc(64'h0FC0, 13'd128, 1'b0, 1'b1);
    addr_hs(1'b0, 64'h0FC0, 8'd3, 0);
    w_burst(4, 1'b0, 1'b0);
    b_resp(2'b00);
    addr_hs(1'b0, 64'h1000, 8'd3, 0);
    w_burst(4, 1'b1, 1'b0);
    b_resp(2'b00);
    finish_check(1'b0);

    // 3: 511-beat read -> 256 + 255
    send_desc(64'h0, 13'd8176, 1'b1, 1'b1);
    addr_hs(1'b1, 64'h0, 8'd255, 0);
    r_burst(256, 1'b0);
    addr_hs(1'b1, 64'h1000, 8'd254, 0);
    r_burst(255, 1'b1);
    finish_check(1'b0);

    // 4: awready stalled 5 cycles, random beat backpressure
    send_desc(64'h2000, 13'd64, 1'b0, 1'b1);
    addr_hs(1'b0, 64'h2000, 8'd3, 5);
    w_burst(4, 1'b1, 1'b1);
    b_resp(2'b00);
    finish_check(1'b0);

    // 5a: SLVERR on the first of two bursts
    send_desc(64'h0FE0, 13'd64, 1'b0, 1'b1);
    addr_hs(1'b0, 64'h0FE0, 8'd1, 0);
    w_burst(2, 1'b0, 1'b0);
    b_resp(2'b10);
    addr_hs(1'b0, 64'h1000, 8'd1, 0);
    w_burst(2, 1'b1, 1'b0);
    b_resp(2'b00);
    finish_check(1'b1);

    // 5b: zero length -> ack and err pulse, no address phase
    send_desc(64'h5000, 13'd0, 1'b0, 1'b0);
    check_bit("zero_len_err", err_o, 1'b1);
    check_bit("zero_len_no_aw", m_axi_awvalid, 1'b0);
    check_bit("zero_len_no_ar", m_axi_arvalid, 1'b0);
    tick();
    check_bit("zero_len_err_drop", err_o, 1'b0);
    check_bit("zero_len_ack_drop", xfer_params_ack_o, 1'b0);
    check_bit("zero_len_still_no_aw", m_axi_awvalid, 1'b0);

    // 6: asynchronous reset in the middle of write data
    send_desc(64'h3000, 13'd64, 1'b0, 1'b1);
    addr_hs(1'b0, 64'h3000, 8'd3, 0);
    soc_it_wvalid_i = 1'b1;
    m_axi_wready    = 1'b1;
    tick();
    tick();
    rst_ni = 1'b0;
    #1;
    check_bit("arst_wvalid", m_axi_wvalid, 1'b0);
    check_bit("arst_wready", soc_it_wready_o, 1'b0);
    check_bit("arst_wlast", m_axi_wlast, 1'b0);
    check_bit("arst_busy", busy_o, 1'b0);
    check_bit("arst_addr_valid", m_axi_awvalid | m_axi_arvalid, 1'b0);
    check_bit("arst_ack_err", xfer_params_ack_o | err_o, 1'b0);
    tick();
    rst_ni          = 1'b1;
    soc_it_wvalid_i = 1'b0;
    m_axi_wready    = 1'b0;
    tick();
    check_bit("post_rst_idle", busy_o | m_axi_awvalid, 1'b0);
    send_desc(64'h4000, 13'd64, 1'b1, 1'b1);
    addr_hs(1'b1, 64'h4000, 8'd3, 0);
    r_burst(4, 1'b1);
    finish_check(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
